// File: rtl/gpio_bank_pkg.sv
// Register map shared by the GPIO bank and anything that talks to it.
// The index values are the bus address bits [4:2] of each register.
package gpio_bank_defs;

    typedef enum logic [2:0] {
        GPIO_IN       = 3'd0,
        GPIO_OUT      = 3'd1,
        GPIO_DIR      = 3'd2,
        GPIO_OUT_SET  = 3'd3,
        GPIO_OUT_CLR  = 3'd4,
        GPIO_OUT_TGL  = 3'd5,
        GPIO_IRQ_EN   = 3'd6,
        GPIO_IRQ_PEND = 3'd7
    } gpio_reg_e;

endpackage

// File: rtl/gpio_debounce.sv
// Single-pin debounce filter: the output follows the input only after the
// input has disagreed with it for CYCLES consecutive clocks.
module gpio_debounce #(
    parameter int CYCLES = 250000
) (
    input  logic clk,
    input  logic resetq,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic          dout_q;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            cnt_q  <= '0;
            dout_q <= 1'b0;
        end else if (din != dout_q) begin
            if (cnt_q == CW'(CYCLES - 1)) begin
                dout_q <= din;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            // Any return to the current level restarts the stability window.
            cnt_q <= '0;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/gpio_bank.sv
// GPIO bank: output/direction registers, synchronised inputs and edge interrupts.
// Define GPIO_BANK_DEBOUNCE_EN to insert a gpio_debounce filter on every input pin.
module gpio_bank
    import gpio_bank_defs::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic [2:0]       addr,
    input  logic             sel,
    input  logic             wstrb,
    input  logic             rstrb,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    output logic             irq
);

    // Edge detection stays disarmed until the reset-value history has flushed
    // through the synchroniser (and the debounce window, when present).
`ifdef GPIO_BANK_DEBOUNCE_EN
    localparam int ARM_CYCLES = SYNC_STAGES + 1 + DEBOUNCE_CYCLES;
`else
    localparam int ARM_CYCLES = SYNC_STAGES + 1;
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
`endif
    localparam int ARM_W = $clog2(ARM_CYCLES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edges;
    logic [ARM_W-1:0] arm_q;
    logic             armed;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] en_q, en_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] rd_val;
    logic [31:0]      rdata_q, rdata_d;
    logic [WIDTH-1:0] wd;
    logic             unused_wdata;

    assign wd           = wdata[WIDTH-1:0];
    assign unused_wdata = ^wdata;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

`ifdef GPIO_BANK_DEBOUNCE_EN
    for (genvar g = 0; g < WIDTH; g++) begin : g_db
        gpio_debounce #(
            .CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .resetq(resetq),
            .din   (sync_q[SYNC_STAGES-1][g]),
            .dout  (filt[g])
        );
    end
`else
    assign filt = sync_q[SYNC_STAGES-1];
`endif

    assign armed = (arm_q == ARM_W'(ARM_CYCLES));
    assign edges = armed ? (filt ^ prev_q) : '0;

    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        en_d  = en_q;
        w1c   = '0;
        if (sel && wstrb) begin
            case (gpio_reg_e'(addr))
                GPIO_OUT:      out_d = wd;
                GPIO_DIR:      dir_d = wd;
                GPIO_OUT_SET:  out_d = out_q | wd;
                GPIO_OUT_CLR:  out_d = out_q & ~wd;
                GPIO_OUT_TGL:  out_d = out_q ^ wd;
                GPIO_IRQ_EN:   en_d  = wd;
                GPIO_IRQ_PEND: w1c   = wd;
                default: ;
            endcase
        end
        // A fresh edge wins over a simultaneous clear of the same bit.
        pend_d = (pend_q & ~w1c) | edges;
    end

    always_comb begin
        rd_val = '0;
        case (gpio_reg_e'(addr))
            GPIO_IN:       rd_val = filt;
            GPIO_OUT:      rd_val = out_q;
            GPIO_DIR:      rd_val = dir_q;
            GPIO_IRQ_EN:   rd_val = en_q;
            GPIO_IRQ_PEND: rd_val = pend_q;
            default:       rd_val = '0;
        endcase
        rdata_d = (sel && rstrb) ? 32'(rd_val) : rdata_q;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            out_q   <= '0;
            dir_q   <= '0;
            en_q    <= '0;
            pend_q  <= '0;
            prev_q  <= '0;
            arm_q   <= '0;
            rdata_q <= '0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            en_q    <= en_d;
            pend_q  <= pend_d;
            prev_q  <= filt;
            rdata_q <= rdata_d;
            if (!armed) arm_q <= arm_q + 1'b1;
        end
    end

    assign pin_out = out_q;
    assign pin_oe  = dir_q;
    assign rdata   = rdata_q;
    assign irq     = |(pend_q & en_q);

endmodule

// File: tb/tb_gpio_bank.sv
// Directed and randomised bench for gpio_bank against a behavioural register/pin model.
module tb_gpio_bank;
    import gpio_bank_defs::*;

    localparam int W  = 8;
    localparam int SS = 2;
`ifdef GPIO_BANK_DEBOUNCE_EN
    localparam int DB  = 4;
    localparam int LAT = SS + DB;
    localparam int ARM = SS + 1 + DB;
`else
    localparam int DB  = 250000;
    localparam int LAT = SS;
    localparam int ARM = SS + 1;
`endif

    logic         clk = 1'b0;
    logic         resetq = 1'b0;
    logic [2:0]   addr = '0;
    logic         sel = 1'b0, wstrb = 1'b0, rstrb = 1'b0;
    logic [31:0]  wdata = '0;
    logic [31:0]  rdata;
    logic [W-1:0] pin_in = '0;
    logic [W-1:0] pin_out, pin_oe;
    logic         irq;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gpio_bank #(
        .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk), .resetq(resetq), .addr(addr), .sel(sel), .wstrb(wstrb),
        .rstrb(rstrb), .wdata(wdata), .rdata(rdata), .pin_in(pin_in),
        .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq)
    );

    // Reference model: pins seen through a delay queue, registers as plain variables.
    logic [W-1:0] m_out = '0, m_dir = '0, m_en = '0, m_pend = '0;
    logic [W-1:0] m_in = '0, m_prev = '0;
    logic [31:0]  m_rdata = '0;
    logic [W-1:0] hq[$];
    int           m_edges = 0;
`ifdef GPIO_BANK_DEBOUNCE_EN
    int           m_cnt[W];
`endif

    always @(posedge clk or negedge resetq) begin : model
        logic [W-1:0] wd, chg, in_next;
`ifdef GPIO_BANK_DEBOUNCE_EN
        logic [W-1:0] sync_pre;
`endif
        if (!resetq) begin
            m_out = '0; m_dir = '0; m_en = '0; m_pend = '0;
            m_in = '0; m_prev = '0; m_rdata = '0; m_edges = 0;
            hq.delete();
`ifdef GPIO_BANK_DEBOUNCE_EN
            for (int i = 0; i < W; i++) m_cnt[i] = 0;
`endif
        end else begin
            wd = wdata[W-1:0];
`ifdef GPIO_BANK_DEBOUNCE_EN
            sync_pre = (hq.size() == SS) ? hq[0] : '0;
`endif
            m_edges++;
            chg = (m_edges > ARM) ? (m_in ^ m_prev) : '0;
            if (sel && rstrb) begin
                case (addr)
                    GPIO_IN:       m_rdata = 32'(m_in);
                    GPIO_OUT:      m_rdata = 32'(m_out);
                    GPIO_DIR:      m_rdata = 32'(m_dir);
                    GPIO_IRQ_EN:   m_rdata = 32'(m_en);
                    GPIO_IRQ_PEND: m_rdata = 32'(m_pend);
                    default:       m_rdata = 32'd0;
                endcase
            end
            if (sel && wstrb) begin
                case (addr)
                    GPIO_OUT:      m_out  = wd;
                    GPIO_DIR:      m_dir  = wd;
                    GPIO_OUT_SET:  m_out  = m_out | wd;
                    GPIO_OUT_CLR:  m_out  = m_out & ~wd;
                    GPIO_OUT_TGL:  m_out  = m_out ^ wd;
                    GPIO_IRQ_EN:   m_en   = wd;
                    GPIO_IRQ_PEND: m_pend = m_pend & ~wd;
                    default: ;
                endcase
            end
            m_pend = m_pend | chg;
            hq.push_back(pin_in);
            if (hq.size() > SS) void'(hq.pop_front());
`ifdef GPIO_BANK_DEBOUNCE_EN
            in_next = m_in;
            for (int i = 0; i < W; i++) begin
                if (sync_pre[i] != m_in[i]) begin
                    m_cnt[i]++;
                    if (m_cnt[i] == DB) begin
                        in_next[i] = sync_pre[i];
                        m_cnt[i]   = 0;
                    end
                end else begin
                    m_cnt[i] = 0;
                end
            end
`else
            in_next = (hq.size() == SS) ? hq[0] : '0;
`endif
            m_prev = m_in;
            m_in   = in_next;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        chk("model_pin_out", 32'(pin_out), 32'(m_out));
        chk("model_pin_oe",  32'(pin_oe),  32'(m_dir));
        chk("model_irq",     32'(irq),     32'(|(m_pend & m_en)));
        chk("model_rdata",   rdata,        m_rdata);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        addr = a; wdata = d; sel = 1'b1; wstrb = 1'b1;
        cyc();
        sel = 1'b0; wstrb = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        addr = a; sel = 1'b1; rstrb = 1'b1;
        cyc();
        sel = 1'b0; rstrb = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        repeat (2) @(negedge clk);
        chk("reset_pin_out", 32'(pin_out), 32'h0);
        chk("reset_pin_oe",  32'(pin_oe),  32'h0);
        chk("reset_rdata",   rdata,        32'h0);
        chk("reset_irq",     32'(irq),     32'h0);
        resetq = 1'b1;
        repeat (ARM + 2) cyc();

        // Output and direction registers, read latency
        wr(GPIO_DIR, 32'hFF);
        wr(GPIO_OUT, 32'hA5);
        chk("dir_pin_oe",  32'(pin_oe),  32'hFF);
        chk("out_pin_out", 32'(pin_out), 32'hA5);
        chk("rd_before_strobe", rdata, 32'h0);
        rd(GPIO_OUT);
        chk("rd_out", rdata, 32'hA5);
        rd(GPIO_OUT_SET);
        chk("rd_wo_zero", rdata, 32'h0);

        // Bitwise set / clear / toggle
        wr(GPIO_OUT_SET, 32'h0F);
        wr(GPIO_OUT_CLR, 32'h80);
        wr(GPIO_OUT_TGL, 32'hFFFF_FF03);
        chk("sct_pin_out", 32'(pin_out), 32'h2C);
        rd(GPIO_OUT);
        chk("sct_rd_out", rdata, 32'h2C);

        // Rising edge on pin 3 with its interrupt enabled
        wr(GPIO_IRQ_PEND, 32'hFF);
        wr(GPIO_IRQ_EN, 32'h08);
        pin_in = 8'h08;
        repeat (LAT - 1) cyc();
        rd(GPIO_IN);
        chk("in_not_yet", rdata, 32'h0);
        rd(GPIO_IN);
        chk("in_bit3", rdata, 32'h08);
        chk("irq_set", 32'(irq), 32'h1);
        rd(GPIO_IRQ_PEND);
        chk("pend_bit3", rdata, 32'h08);
        wr(GPIO_IRQ_PEND, 32'h08);
        chk("irq_cleared", 32'(irq), 32'h0);

        // Clear racing a new edge on the same bit
        pin_in = 8'h00;
        repeat (LAT + 2) cyc();
        chk("irq_fall", 32'(irq), 32'h1);
        wr(GPIO_IRQ_PEND, 32'h08);
        pin_in = 8'h08;
        repeat (LAT) cyc();
        wr(GPIO_IRQ_PEND, 32'h08);
        chk("race_irq", 32'(irq), 32'h1);
        rd(GPIO_IRQ_PEND);
        chk("race_pend", rdata, 32'h08);

`ifdef GPIO_BANK_DEBOUNCE_EN
        // Short glitch is filtered, longer pulse passes
        wr(GPIO_IRQ_PEND, 32'hFF);
        wr(GPIO_IRQ_EN, 32'h20);
        pin_in = 8'h28;
        repeat (3) cyc();
        pin_in = 8'h08;
        repeat (12) cyc();
        rd(GPIO_IRQ_PEND);
        chk("glitch_no_pend", rdata, 32'h0);
        rd(GPIO_IN);
        chk("glitch_in", rdata, 32'h08);
        pin_in = 8'h28;
        repeat (6) cyc();
        pin_in = 8'h08;
        rd(GPIO_IN);
        chk("pulse_in", rdata, 32'h28);
        repeat (2) cyc();
        rd(GPIO_IRQ_PEND);
        chk("pulse_pend", rdata, 32'h20);
        chk("pulse_irq", 32'(irq), 32'h1);
        repeat (12) cyc();
`endif

        // Randomised bus traffic and pin activity
        for (int n = 0; n < 400; n++) begin
            sel   = ($urandom_range(0, 3) != 0);
            wstrb = 1'($urandom_range(0, 1));
            rstrb = 1'($urandom_range(0, 1));
            addr  = 3'($urandom_range(0, 7));
            wdata = $urandom;
            if ($urandom_range(0, 4) == 0) pin_in = pin_in ^ W'(1 << $urandom_range(0, W - 1));
            cyc();
        end
        sel = 1'b0; wstrb = 1'b0; rstrb = 1'b0;

        // Reset in the middle of activity with all pins high
        wr(GPIO_DIR, 32'hFF);
        wr(GPIO_OUT, 32'h5A);
        wr(GPIO_IRQ_EN, 32'hFF);
        rd(GPIO_OUT);
        pin_in = 8'hFF;
        repeat (3) cyc();
        #2 resetq = 1'b0;
        #1;
        chk("rst_pin_out", 32'(pin_out), 32'h0);
        chk("rst_pin_oe",  32'(pin_oe),  32'h0);
        chk("rst_rdata",   rdata,        32'h0);
        chk("rst_irq",     32'(irq),     32'h0);
        repeat (2) @(negedge clk);
        resetq = 1'b1;
        repeat (ARM + 4) cyc();
        rd(GPIO_IRQ_PEND);
        chk("rst_no_pend", rdata, 32'h0);
        rd(GPIO_DIR);
        chk("rst_dir", rdata, 32'h0);
        rd(GPIO_IRQ_EN);
        chk("rst_en", rdata, 32'h0);
        rd(GPIO_IN);
        chk("rst_in_high", rdata, 32'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
